// File: rtl/work_loader_if.sv
// Handshake bundle between the host byte link, work_loader and the nonce-search consumer.
interface work_loader_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [607:0]     hdr;
  logic [31:0]      nonce_start;
  logic [31:0]      nonce_end;
  logic             work_valid;
  logic             work_ready;
  logic             err_chk;
  logic             err_timeout;
  logic             err_range;
  logic [CNT_W-1:0] frames_ok;

  modport master (
    output rx_data, rx_valid, work_ready,
    input  rx_ready, hdr, nonce_start, nonce_end, work_valid,
           err_chk, err_timeout, err_range, frames_ok
  );

  modport slave (
    input  rx_data, rx_valid, work_ready,
    output rx_ready, hdr, nonce_start, nonce_end, work_valid,
           err_chk, err_timeout, err_range, frames_ok
  );
endinterface

// File: rtl/work_loader.sv
// Sync-hunting frame assembler that hands one checksummed work unit to the nonce-search element.
// Optional nonce range rejection is enabled by defining WORK_LOADER_RANGE_CHECK_EN.
module work_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         CNT_W          = 16
) (
  input logic          CLK,
  input logic          nreset,
  work_loader_if.slave lif
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]      LAST_IDX = 7'd83;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHKSUM,
    HOLD
  } state_e;

  state_e           state_q;
  logic [6:0]       byteIdx_q;
  logic [7:0]       acc_q;
  logic [TO_W-1:0]  timeoutCnt_q;
  logic [671:0]     stage_q;
  logic             rxReady_q;
  logic             workValid_q;
  logic             errChk_q;
  logic             errTimeout_q;
  logic [607:0]     hdr_q;
  logic [31:0]      nonceStart_q;
  logic [31:0]      nonceEnd_q;
  logic [CNT_W-1:0] framesOk_q;
`ifdef WORK_LOADER_RANGE_CHECK_EN
  logic             errRange_q;
`endif

  logic             accept;
  logic             chkPass;
  logic             stallExpired;
  logic [7:0]       acc_d;
  logic [671:0]     stage_d;
  logic [TO_W-1:0]  timeoutCnt_d;

  always_comb begin
    accept       = lif.rx_valid && rxReady_q;
    acc_d        = acc_q ^ lif.rx_data;
    stage_d      = {stage_q[663:0], lif.rx_data};
    timeoutCnt_d = timeoutCnt_q + 1'b1;
    chkPass      = (acc_q == lif.rx_data);
    stallExpired = !accept && (timeoutCnt_q == TO_LAST);
  end

  // Staging shifts in the 84 payload bytes; the oldest byte ends up at the top so
  // that the first header byte lands in hdr[607:600] and the nonces are big-endian.
  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      byteIdx_q    <= '0;
      acc_q        <= '0;
      timeoutCnt_q <= '0;
      stage_q      <= '0;
      rxReady_q    <= 1'b0;
      workValid_q  <= 1'b0;
      errChk_q     <= 1'b0;
      errTimeout_q <= 1'b0;
      hdr_q        <= '0;
      nonceStart_q <= '0;
      nonceEnd_q   <= '0;
      framesOk_q   <= '0;
`ifdef WORK_LOADER_RANGE_CHECK_EN
      errRange_q   <= 1'b0;
`endif
    end else begin
      errChk_q     <= 1'b0;
      errTimeout_q <= 1'b0;
      rxReady_q    <= 1'b1;
`ifdef WORK_LOADER_RANGE_CHECK_EN
      errRange_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept && (lif.rx_data == SYNC_BYTE)) begin
            state_q      <= PAYLOAD;
            byteIdx_q    <= '0;
            acc_q        <= '0;
            timeoutCnt_q <= '0;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            stage_q      <= stage_d;
            acc_q        <= acc_d;
            byteIdx_q    <= byteIdx_q + 1'b1;
            timeoutCnt_q <= '0;
            if (byteIdx_q == LAST_IDX) begin
              state_q <= CHKSUM;
            end
          end else if (stallExpired) begin
            errTimeout_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end
        CHKSUM: begin
          if (accept) begin
            timeoutCnt_q <= '0;
            if (!chkPass) begin
              errChk_q <= 1'b1;
              state_q  <= IDLE;
`ifdef WORK_LOADER_RANGE_CHECK_EN
            end else if (stage_q[31:0] < stage_q[63:32]) begin
              errRange_q <= 1'b1;
              state_q    <= IDLE;
`endif
            end else begin
              state_q      <= HOLD;
              rxReady_q    <= 1'b0;
              workValid_q  <= 1'b1;
              hdr_q        <= stage_q[671:64];
              nonceStart_q <= stage_q[63:32];
              nonceEnd_q   <= stage_q[31:0];
            end
          end else if (stallExpired) begin
            errTimeout_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end
        HOLD: begin
          rxReady_q <= 1'b0;
          if (lif.work_ready) begin
            workValid_q <= 1'b0;
            framesOk_q  <= framesOk_q + 1'b1;
            rxReady_q   <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lif.rx_ready    = rxReady_q;
  assign lif.hdr         = hdr_q;
  assign lif.nonce_start = nonceStart_q;
  assign lif.nonce_end   = nonceEnd_q;
  assign lif.work_valid  = workValid_q;
  assign lif.err_chk     = errChk_q;
  assign lif.err_timeout = errTimeout_q;
  assign lif.frames_ok   = framesOk_q;
`ifdef WORK_LOADER_RANGE_CHECK_EN
  assign lif.err_range   = errRange_q;
`else
  assign lif.err_range   = 1'b0;
`endif

endmodule

// File: tb/tb_work_loader.sv
// Randomized bench for work_loader: frames are built from a byte array and the expected
// work unit, error pulses and handoff count are derived from the framing rules.
module tb_work_loader;

  localparam int         TIMEOUT = 50;
  localparam int         CNT_W   = 16;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic clk = 1'b0;
  logic nreset;

  always #5 clk = ~clk;

  work_loader_if #(.CNT_W(CNT_W)) bus ();

  work_loader #(
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (CNT_W)
  ) dut (
    .CLK   (clk),
    .nreset(nreset),
    .lif   (bus.slave)
  );

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0]       payload [84];
  logic [607:0]     expHdr;
  logic [31:0]      expStart;
  logic [31:0]      expEnd;
  logic [CNT_W-1:0] expFrames;
  int               expChk = 0;
  int               expTo = 0;
  int               expRange = 0;
  int               pulsesChk = 0;
  int               pulsesTo = 0;
  int               pulsesRange = 0;
  int               bytesTaken = 0;
  logic [2:0]       prevErrVec = 3'b000;

  task automatic checkOutput(input string tag, input logic [607:0] observed,
                             input logic [607:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [607:0] modelHdr();
    logic [607:0] h;
    h = '0;
    for (int i = 0; i < 76; i++) h[607-8*i -: 8] = payload[i];
    return h;
  endfunction

  function automatic logic [7:0] randomNonSync();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == SYNC) b = 8'h5A;
    return b;
  endfunction

  task automatic setNonces(input logic [31:0] s, input logic [31:0] e);
    for (int k = 0; k < 4; k++) begin
      payload[76+k] = s[31-8*k -: 8];
      payload[80+k] = e[31-8*k -: 8];
    end
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 84; i++) payload[i] = 8'($urandom);
  endtask

  // One clock: note whether a byte is taken on this edge, then sample just after it.
  task automatic step();
    logic       took;
    logic [2:0] errVec;
    took = bus.rx_valid && bus.rx_ready;
    @(posedge clk);
    #1;
    if (took) bytesTaken++;
    errVec = {bus.err_chk, bus.err_timeout, bus.err_range};
    if (bus.err_chk) pulsesChk++;
    if (bus.err_timeout) pulsesTo++;
    if (bus.err_range) pulsesRange++;
    if (errVec != 3'b000) begin
      checkOutput("err_onehot", 608'(int'(errVec[0]) + int'(errVec[1]) + int'(errVec[2])), 608'(1));
      checkOutput("err_width", 608'(errVec & prevErrVec), 608'(0));
    end
    prevErrVec = errVec;
  endtask

  task automatic sendGap(input int gapMax);
    int n;
    n = $urandom_range(gapMax, 0);
    bus.rx_valid = 1'b0;
    repeat (n) begin
      bus.rx_data = 8'($urandom);
      step();
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int guard;
    bit done;
    logic ready;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    guard = 0;
    done  = 1'b0;
    while (!done && guard < 200) begin
      ready = bus.rx_ready;
      step();
      if (ready) done = 1'b1;
      guard++;
    end
    bus.rx_valid = 1'b0;
    if (!done) checkOutput("byte_accept_bound", 608'(0), 608'(1));
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, "_hdr"}, bus.hdr, expHdr);
    checkOutput({tag, "_nonce_start"}, 608'(bus.nonce_start), 608'(expStart));
    checkOutput({tag, "_nonce_end"}, 608'(bus.nonce_end), 608'(expEnd));
  endtask

  task automatic doReset();
    bus.rx_valid   = 1'b0;
    bus.work_ready = 1'b0;
    nreset = 1'b0;
    #1;
    checkOutput("rst_work_valid", 608'(bus.work_valid), 608'(0));
    checkOutput("rst_rx_ready", 608'(bus.rx_ready), 608'(0));
    checkOutput("rst_frames_ok", 608'(bus.frames_ok), 608'(0));
    checkOutput("rst_hdr", bus.hdr, 608'(0));
    checkOutput("rst_nonces", 608'({bus.nonce_start, bus.nonce_end}), 608'(0));
    checkOutput("rst_errs", 608'({bus.err_chk, bus.err_timeout, bus.err_range}), 608'(0));
    @(posedge clk);
    #1;
    checkOutput("rst_rx_ready_held", 608'(bus.rx_ready), 608'(0));
    nreset = 1'b1;
    prevErrVec = 3'b000;
    step();
    checkOutput("rst_rx_ready_up", 608'(bus.rx_ready), 608'(1));
    expHdr    = '0;
    expStart  = '0;
    expEnd    = '0;
    expFrames = '0;
  endtask

  task automatic applyStimulus(input logic [7:0] chkFlip, input int stallLen,
                               input int readyDelay, input int gapMax, input bit holdReset);
    logic [7:0]  chk;
    logic [31:0] nStart;
    logic [31:0] nEnd;
    bit          rangeReject;
    int          takenBefore;
    chk = '0;
    for (int i = 0; i < 84; i++) chk ^= payload[i];
    nStart = {payload[76], payload[77], payload[78], payload[79]};
    nEnd   = {payload[80], payload[81], payload[82], payload[83]};
    rangeReject = 1'b0;
`ifdef WORK_LOADER_RANGE_CHECK_EN
    rangeReject = (nEnd < nStart);
`endif
    bus.work_ready = (readyDelay == 0);
    sendGap(gapMax);
    sendByte(SYNC);
    for (int i = 0; i < 84; i++) begin
      if (i == 10 && stallLen > 0) begin
        for (int c = 1; c <= stallLen && c <= TIMEOUT; c++) begin
          step();
          if (c == TIMEOUT - 1) checkOutput("stall_no_abort_yet", 608'(bus.err_timeout), 608'(0));
          if (c == TIMEOUT) checkOutput("err_timeout", 608'(bus.err_timeout), 608'(1));
        end
        if (stallLen >= TIMEOUT) begin
          expTo++;
          step();
          checkOutput("timeout_clear", 608'(bus.err_timeout), 608'(0));
          checkOutput("timeout_rx_ready", 608'(bus.rx_ready), 608'(1));
          checkOutput("timeout_work_valid", 608'(bus.work_valid), 608'(0));
          checkHeld("timeout");
          bus.work_ready = 1'b0;
          return;
        end
      end else begin
        sendGap(gapMax);
      end
      sendByte(payload[i]);
    end
    sendGap(gapMax);
    sendByte(chk ^ chkFlip);
    if (chkFlip != 8'h00) begin
      expChk++;
      checkOutput("err_chk", 608'(bus.err_chk), 608'(1));
      checkOutput("bad_chk_work_valid", 608'(bus.work_valid), 608'(0));
      checkHeld("bad_chk");
      step();
      checkOutput("err_chk_clear", 608'(bus.err_chk), 608'(0));
      checkOutput("bad_chk_frames_ok", 608'(bus.frames_ok), 608'(expFrames));
    end else if (rangeReject) begin
      expRange++;
      checkOutput("err_range", 608'(bus.err_range), 608'(1));
      checkOutput("range_work_valid", 608'(bus.work_valid), 608'(0));
      checkHeld("range");
      step();
      checkOutput("err_range_clear", 608'(bus.err_range), 608'(0));
    end else begin
      expHdr   = modelHdr();
      expStart = nStart;
      expEnd   = nEnd;
      checkOutput("work_valid_up", 608'(bus.work_valid), 608'(1));
      checkOutput("hold_rx_ready", 608'(bus.rx_ready), 608'(0));
      checkHeld("good");
      if (holdReset) begin
        doReset();
        return;
      end
      if (readyDelay > 0) begin
        takenBefore  = bytesTaken;
        bus.rx_valid = 1'b1;
        for (int d = 0; d < readyDelay; d++) begin
          bus.rx_data = 8'($urandom);
          step();
        end
        checkOutput("bp_work_valid", 608'(bus.work_valid), 608'(1));
        checkOutput("bp_rx_ready", 608'(bus.rx_ready), 608'(0));
        checkOutput("bp_bytes_taken", 608'(bytesTaken - takenBefore), 608'(0));
        bus.rx_valid   = 1'b0;
        bus.work_ready = 1'b1;
      end
      step();
      expFrames++;
      checkOutput("handoff_work_valid", 608'(bus.work_valid), 608'(0));
      checkOutput("handoff_frames_ok", 608'(bus.frames_ok), 608'(expFrames));
      checkOutput("handoff_rx_ready", 608'(bus.rx_ready), 608'(1));
      checkHeld("after_handoff");
    end
    bus.work_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nreset         = 1'b1;
    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.work_ready = 1'b0;
    #1;
    doReset();

    // Directed frame from the plan, consumer ready from the start.
    for (int i = 0; i < 76; i++) payload[i] = 8'(i);
    setNonces(32'h0000_0010, 32'h0000_00FF);
    applyStimulus(8'h00, 0, 0, 0, 1'b0);
    checkOutput("hdr_first_byte", 608'(bus.hdr[607:600]), 608'(8'h00));
    checkOutput("hdr_last_byte", 608'(bus.hdr[7:0]), 608'(8'h4B));
    checkOutput("nonce_start_plan", 608'(bus.nonce_start), 608'(32'h10));
    checkOutput("nonce_end_plan", 608'(bus.nonce_end), 608'(32'hFF));

    sendByte(8'h00);
    sendByte(8'h13);
    sendByte(8'hFF);
    applyStimulus(8'h00, 0, 0, 0, 1'b0);

    fillRandom();
    applyStimulus(8'h01, 0, 0, 1, 1'b0);
    fillRandom();
    applyStimulus(8'h00, 0, 0, 1, 1'b0);

    fillRandom();
    applyStimulus(8'h00, TIMEOUT, 0, 0, 1'b0);
    fillRandom();
    applyStimulus(8'h00, TIMEOUT - 1, 0, 0, 1'b0);

    fillRandom();
    applyStimulus(8'h00, 0, 20, 0, 1'b0);

    fillRandom();
    setNonces(32'h0000_0100, 32'h0000_00FF);
    applyStimulus(8'h00, 0, 0, 0, 1'b0);

    // Reset part-way through a frame, then while a work unit is pending.
    sendByte(SYNC);
    for (int i = 0; i < 30; i++) sendByte(8'($urandom));
    doReset();
    fillRandom();
    applyStimulus(8'h00, 0, 5, 0, 1'b1);
    fillRandom();
    applyStimulus(8'h00, 0, 2, 1, 1'b0);

    for (int f = 0; f < 12; f++) begin
      int         kind;
      int         stall;
      int         nGarb;
      logic [7:0] flip;
      fillRandom();
      kind  = $urandom_range(5, 0);
      flip  = (kind == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      stall = (kind == 1) ? TIMEOUT + $urandom_range(5, 0) : ((kind == 2) ? TIMEOUT - 1 : 0);
      nGarb = $urandom_range(2, 0);
      for (int g = 0; g < nGarb; g++) sendByte(randomNonSync());
      applyStimulus(flip, stall, $urandom_range(4, 0), 2, 1'b0);
    end

    checkOutput("total_err_chk", 608'(pulsesChk), 608'(expChk));
    checkOutput("total_err_timeout", 608'(pulsesTo), 608'(expTo));
    checkOutput("total_err_range", 608'(pulsesRange), 608'(expRange));
    checkOutput("final_frames_ok", 608'(bus.frames_ok), 608'(expFrames));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
